// File: rtl/if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage
//
// Instruction-fetch stage with a DEPTH-entry prefetch queue. It runs
// sequential fetches ahead of decode over a variable-latency instruction
// memory handshake (at most one request outstanding). Decode stalls are
// absorbed in the queue. A taken branch from EX flushes everything in flight.
//
// Optional feature (compile-time macro):
//   IF_BYPASS_EN - when the queue is empty, an accepted memory response is
//                  presented at the outputs in the same cycle. If decode
//                  takes it, it is never written to the queue.
//
// Parameters:
//   XLEN      PC / instruction width
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  first PC fetched after reset
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_redirect         taken branch/jump: flush and refetch
//   ex_redirect_pc      new fetch PC when ex_redirect=1
//   id_stall            decode hazard, head entry must not be consumed
//   proc2Imem_req       fetch request valid this cycle
//   proc2Imem_addr      word-aligned request address
//   Imem2proc_valid     in-order response valid
//   Imem2proc_data      response instruction
//   if_PC_out           PC of head entry
//   if_NPC_out          if_PC_out + 4
//   if_IR_out           instruction of head entry
//   if_valid_inst_out   head entry valid
// ----------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_pc,
    input  logic            id_stall,
    output logic            proc2Imem_req,
    output logic [XLEN-1:0] proc2Imem_addr,
    input  logic            Imem2proc_valid,
    input  logic [XLEN-1:0] Imem2proc_data,
    output logic [XLEN-1:0] if_PC_out,
    output logic [XLEN-1:0] if_NPC_out,
    output logic [XLEN-1:0] if_IR_out,
    output logic            if_valid_inst_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_entry_t;

    // Architectural state
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pend_pc;   // PC of the outstanding request
    logic            pend;      // one request outstanding
    logic            drop;      // next response belongs to a flushed request
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    fetch_entry_t    q_mem [DEPTH];
    fetch_entry_t    hold_e;    // last entry shown, displayed while invalid

    // Per-cycle control
    logic            rsp_ok;    // response belongs to a live request
    logic            issue;
    logic            push;
    logic            pop;
    logic            byp_show;
    logic            byp_take;
    logic [CW:0]     occ;       // entries held plus slot reserved for pend
    fetch_entry_t    rsp_e;
    fetch_entry_t    cur_e;
    logic            cur_vld;

    // ------------------------------------------------------------------
    // Issue / accept / pop decisions
    // ------------------------------------------------------------------
    always_comb begin
        occ      = {1'b0, count} + {{CW{1'b0}}, pend};
        // A response with nothing outstanding is ignored (pend gates it).
        rsp_ok   = Imem2proc_valid & pend & ~drop & ~ex_redirect;
        // The outstanding request already owns a queue slot, so only issue
        // when there is room for one more beyond it.
        issue    = ~rst & ~ex_redirect & (~pend | Imem2proc_valid) &
                   (occ < DEPTH_C);
        rsp_e.pc = pend_pc;
        rsp_e.ir = Imem2proc_data;
`ifdef IF_BYPASS_EN
        byp_show = rsp_ok & (count == '0);
        byp_take = byp_show & ~id_stall;
`else
        byp_show = 1'b0;
        byp_take = 1'b0;
`endif
        push     = rsp_ok & ~byp_take;
        pop      = (count != '0) & ~id_stall & ~ex_redirect;
    end

    // ------------------------------------------------------------------
    // Output selection: bypassed response, queue head, or held last value
    // ------------------------------------------------------------------
    always_comb begin
        cur_e   = hold_e;
        cur_vld = 1'b0;
        if (byp_show) begin
            cur_e   = rsp_e;
            cur_vld = 1'b1;
        end else if (count != '0) begin
            cur_e   = q_mem[head];
            cur_vld = 1'b1;
        end
    end

    assign proc2Imem_req     = issue;
    assign proc2Imem_addr    = {fetch_pc[XLEN-1:2], 2'b00};
    assign if_PC_out         = cur_e.pc;
    assign if_IR_out         = cur_e.ir;
    assign if_NPC_out        = cur_e.pc + XLEN'(4);
    assign if_valid_inst_out = cur_vld;

    // ------------------------------------------------------------------
    // Queue storage: data only, no reset needed (guarded by count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push && !rst)
            q_mem[tail] <= rsp_e;
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            pend     <= 1'b0;
            drop     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            hold_e   <= '0;
        end else begin
            if (cur_vld)
                hold_e <= cur_e;

            if (ex_redirect) begin
                // Flush wins over every other event this cycle.
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= ex_redirect_pc;
                if (pend && !Imem2proc_valid) begin
                    drop <= 1'b1;       // request still owed: discard its reply
                end else if (pend) begin
                    pend <= 1'b0;       // reply arrived now and is thrown away
                    drop <= 1'b0;
                end
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    pend_pc  <= fetch_pc;
                    pend     <= 1'b1;
                end else if (Imem2proc_valid && pend) begin
                    pend <= 1'b0;
                end

                if (Imem2proc_valid && pend && drop)
                    drop <= 1'b0;

                if (push)
                    tail <= tail + PW'(1);
                if (pop)
                    head <= head + PW'(1);

                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue, a variable-latency instruction-memory handshake and redirect flush. It sits between instruction memory and the IF/ID pipeline register. It fetches sequential PCs ahead of decode, absorbs decode stalls without losing fetched words, and discards in-flight and queued instructions on a taken branch from EX.

## Interface
- XLEN, 32, PC/instruction width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 0, PC fetched first after reset
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ex_redirect  in  1  taken branch/jump; flush and refetch
- ex_redirect_pc  in  XLEN  new fetch PC when ex_redirect=1
- id_stall  in  1  decode hazard; head entry must not be consumed
- proc2Imem_req  out  1  fetch request valid this cycle
- proc2Imem_addr  out  XLEN  request address, {fetch_pc[XLEN-1:2],2'b0}
- Imem2proc_valid  in  1  response valid (≥1 cycle after its request, in order)
- Imem2proc_data  in  XLEN  response instruction
- if_PC_out  out  XLEN  PC of head entry
- if_NPC_out  out  XLEN  if_PC_out + 4
- if_IR_out  out  XLEN  instruction of head entry
- if_valid_inst_out  out  1  head entry valid

## Operation
- State: fetch_pc, pend (one request outstanding), drop (discard next response), queue of {pc, ir} with head/tail pointers, count 0..DEPTH.
- Issue: proc2Imem_req = ~ex_redirect & (~pend | Imem2proc_valid) & (count + pend < DEPTH). On issue: fetch_pc += 4, pend ← 1, and the request PC is recorded as pend_pc.
- Response: when Imem2proc_valid & ~drop, push {pend_pc, data} into the queue. When drop=1, discard the response and clear drop. A response clears pend unless a new request issues in the same cycle.
- Pop: when count≠0 & ~id_stall & ~ex_redirect, the head entry is consumed. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Redirect has priority over everything: count←0, pointers←0, fetch_pc←ex_redirect_pc, no request issued.
  - If pend=1 and there is no response this cycle: drop←1.
  - A response arriving in the redirect cycle is discarded.
  - pend←0 only if there is no unanswered request.
- Outputs come from the head entry: if_valid_inst_out = (count≠0). Without the bypass option, PC/IR hold the last head value while invalid.
- The queue never overflows, because issue reserves a slot for the outstanding request.
- The memory response must not arrive with no request outstanding. The bench flags this condition; the design ignores such a response.

## Timing
- Reset values: fetch_pc=RESET_PC, pend=0, drop=0, count=0, if_valid_inst_out=0, if_PC_out=0, if_NPC_out=4, if_IR_out=0.
- The first proc2Imem_req is asserted in the first cycle after rst deasserts, with addr=RESET_PC.
- With a 1-cycle memory (response cycle N+1 for a request in cycle N), there is one request per cycle at steady state.
- A response pushed in cycle N is visible at the outputs in cycle N+1.
- After redirect in cycle N:
  - first request to ex_redirect_pc in cycle N+1, or later if a dropped response is still owed;
  - outputs are invalid from cycle N+1.
- A stall of any length holds the head entry stable. Fetch continues until the queue is full, then stops until a pop.
- rst asserted mid-fetch: all state returns to reset values next cycle, and a later response to the aborted request is ignored (pend=0).

## Configuration
- IF_BYPASS_EN defined: when count=0 and an accepted response arrives, the outputs show {pend_pc, Imem2proc_data} with if_valid_inst_out=1 in the same cycle.
  - If ~id_stall, the entry is consumed and not written to the queue.
  - Otherwise it is queued.
  - This saves one cycle of fetch-to-decode latency.
- IF_BYPASS_EN undefined: all responses go through the queue (latency as in Timing). No combinational path from Imem2proc_* to if_*_out.

## Test plan
- Reset, DEPTH=4, 1-cycle memory returning data=addr|0x13, no stall -> req at PCs 0,4,8,…; outputs valid from cycle 3 (2 with bypass), PC/IR sequence 0/0x13, 4/0x17, consecutive every cycle.
- Hold id_stall=1 for 10 cycles -> exactly 4 entries queued, req deasserted, head PC constant; on release, 4 back-to-back pops, then fetch resumes with no gap or duplicate.
- 3-cycle memory latency -> one request per 3 cycles, pend never exceeds 1, every PC delivered once in order.
- ex_redirect=1, ex_redirect_pc=0x100 while a request to 0x20 is pending (response 2 cycles later) -> queue empty next cycle, 0x20 response discarded, next valid output PC=0x100 with no stale instruction.
- Redirect in the same cycle as a response and a pop -> response discarded, no pop counted, count=0, next fetch to redirect PC.
- rst asserted with pend=1 and 3 entries queued -> next cycle all outputs at reset values; the late response does not appear; fetch restarts at RESET_PC.
